// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage sitting between the program ROM and decode.
//
// Keeps the fetch PC and issues one ROM word read per cycle while the prefetch FIFO
// has space. Read data (one cycle of latency) is captured into the FIFO. The FIFO
// head is offered to decode with first-word fall-through. A redirect flushes the
// FIFO, cancels the outstanding read and restarts fetch at redirect_pc.
//
// Optional feature macro: IFETCH_ADDR_CHECK_EN
//   When defined, a misaligned PC or a PC beyond the ROM is not sent to the ROM.
//   A faulting NOP entry (fault=1) is queued instead, and fetch halts until the
//   next redirect. When undefined, instr_fault is 0, PC bits [1:0] are ignored
//   and PCs above the ROM alias into it.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rom_ce, rom_addr  ROM read request (combinational) and word address
//   rom_rdata(_valid) ROM read data, valid one cycle after rom_ce
//   redirect_valid/pc flush and restart fetch at a new byte PC
//   instr_valid/instr/instr_pc/instr_fault  FIFO head to decode
//   instr_ready       decode accepts the head

module ifetch_unit #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  rom_ce,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_rdata,
    input  logic                  rom_rdata_valid,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic                  instr_fault,
    input  logic                  instr_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;
    logic             halted_q, halted_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] instr_mem [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic             capture;
    logic             fault_push;
    logic             fetch_en;
    logic             room;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      push_instr;
    logic [31:0]      push_pc;

    assign pop = instr_valid & instr_ready;

    // Count the outstanding read as occupied so its data always has a slot.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign room      = occupancy < OCC_W'(FIFO_DEPTH);
    assign fetch_en  = rst_n & ~redirect_valid & ~halted_q & room;

`ifdef IFETCH_ADDR_CHECK_EN
    logic             addr_bad;
    logic             fault_mem [FIFO_DEPTH];

    assign addr_bad = (|fetch_pc_q[1:0]) | ((fetch_pc_q >> (ADDR_WIDTH + 2)) != 32'd0);
    assign rom_ce   = fetch_en & ~addr_bad;
    // Wait for any outstanding read to land first so the fault entry stays in order
    // and never collides with a capture in the same cycle.
    assign fault_push  = fetch_en & addr_bad & ~inflight_q;
    assign instr_fault = instr_valid & fault_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fault_mem[wr_ptr_q] <= fault_push;
        end
    end
`else
    assign rom_ce      = fetch_en;
    assign fault_push  = 1'b0;
    assign instr_fault = 1'b0;
`endif

    assign rom_addr = fetch_pc_q[ADDR_WIDTH+1:2];

    // Data returning in a redirect cycle belongs to the old stream and is dropped.
    assign capture    = rom_rdata_valid & inflight_q & ~kill_q & ~redirect_valid;
    assign push       = rst_n & (capture | fault_push);
    assign push_instr = fault_push ? 32'h0000_0013 : rom_rdata;
    assign push_pc    = fault_push ? fetch_pc_q : req_pc_q;

    assign instr_valid = rst_n & (count_q != '0) & ~redirect_valid;
    assign instr       = instr_mem[rd_ptr_q];
    assign instr_pc    = pc_mem[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = rom_ce;
        halted_d   = halted_q;
        kill_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (rom_ce) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (fault_push) begin
            halted_d = 1'b1;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            // Only a read still outstanding after this cycle needs killing.
            kill_d     = inflight_q & ~rom_rdata_valid;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            halted_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            halted_q   <= halted_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= push_instr;
            pc_mem[wr_ptr_q]    <= push_pc;
        end
    end

endmodule
